// File: rtl/multicycle_main_decoder_if.sv
// Control bundle between the instruction register / datapath and the main decoder.
// The decoder side takes the master modport; the datapath side takes the slave modport.
interface multicycle_main_decoder_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] ResultSrc;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic       PCUpdate;
    logic       AddrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       beq;
    logic       bne;
    logic       bge;
    logic       blt;

    modport master (
        input  opcode, funct3,
        output ResultSrc, ALUOp, ALUSrcA, ALUSrcB,
        output RegWrite, PCUpdate, AddrSrc, MemWrite, IRWrite,
        output beq, bne, bge, blt
    );

    modport slave (
        output opcode, funct3,
        input  ResultSrc, ALUOp, ALUSrcA, ALUSrcB,
        input  RegWrite, PCUpdate, AddrSrc, MemWrite, IRWrite,
        input  beq, bne, bge, blt
    );
endinterface

// File: rtl/multicycle_main_decoder.sv
// Main control FSM of the multicycle RV32I core: Fetch/Decode/Execute/Memory/Writeback
// sequencing with Moore datapath controls and funct3-decoded branch strobes in Branch.
module multicycle_main_decoder (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_main_decoder_if.master bus
);

    typedef enum logic [3:0] {
        S0  = 4'd0,   // Fetch
        S1  = 4'd1,   // Decode
        S2  = 4'd2,   // MemAdr
        S3  = 4'd3,   // MemRead
        S4  = 4'd4,   // MemWB
        S5  = 4'd5,   // MemWrite
        S6  = 4'd6,   // ExecuteR
        S7  = 4'd7,   // ALUWB
        S8  = 4'd8,   // ExecuteI
        S9  = 4'd9,   // JAL
        S10 = 4'd10   // Branch
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S0;
        case (state)
            S0: next_state = S1;
            S1: begin
                case (bus.opcode)
                    OP_LW,
                    OP_SW:     next_state = S2;
                    OP_RTYPE:  next_state = S6;
                    OP_ITYPE:  next_state = S8;
                    OP_JAL:    next_state = S9;
                    OP_BRANCH: next_state = S10;
                    default:   next_state = S0;
                endcase
            end
            S2:      next_state = (bus.opcode == OP_LW) ? S3 : S5;
            S3:      next_state = S4;
            S4:      next_state = S0;
            S5:      next_state = S0;
            S6:      next_state = S7;
            S7:      next_state = S0;
            S8:      next_state = S7;
            S9:      next_state = S7;
            S10:     next_state = S0;
            default: next_state = S0;
        endcase
    end

    always_comb begin
        bus.ResultSrc = '0;
        bus.ALUOp     = '0;
        bus.ALUSrcA   = '0;
        bus.ALUSrcB   = '0;
        bus.RegWrite  = 1'b0;
        bus.PCUpdate  = 1'b0;
        bus.AddrSrc   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.beq       = 1'b0;
        bus.bne       = 1'b0;
        bus.bge       = 1'b0;
        bus.blt       = 1'b0;
        case (state)
            S0: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.PCUpdate  = 1'b1;
            end
            S1: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            S2: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            S3: bus.AddrSrc = 1'b1;
            S4: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S5: begin
                bus.AddrSrc  = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S6: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
            end
            S7: bus.RegWrite = 1'b1;
            S8: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 2'b10;
            end
            S9: begin
                bus.ALUSrcA  = 2'b01;
                bus.ALUSrcB  = 2'b10;
                bus.PCUpdate = 1'b1;
            end
            S10: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b01;
                // Strobes are the only Mealy outputs: they follow funct3 within Branch.
                case (bus.funct3)
                    3'b000:  bus.beq = 1'b1;
                    3'b001:  bus.bne = 1'b1;
                    3'b100:  bus.blt = 1'b1;
                    3'b101:  bus.bge = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_decoder.sv
// Bench for multicycle_main_decoder: directed instruction traces plus randomized
// instruction streams compared against a per-instruction state-path and control table model.
module tb_multicycle_main_decoder;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    multicycle_main_decoder_if bus ();

    multicycle_main_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {ResultSrc, ALUOp, ALUSrcA, ALUSrcB, RegWrite, PCUpdate, AddrSrc, MemWrite, IRWrite, beq, bne, bge, blt}
    logic [16:0] obs;
    assign obs = {bus.ResultSrc, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.PCUpdate,
                  bus.AddrSrc, bus.MemWrite, bus.IRWrite, bus.beq, bus.bne, bus.bge, bus.blt};

    localparam logic [16:0] FETCH_OUT = {2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000};

    int          tr_st [8];
    logic [16:0] tr_out[8];
    int          tr_len;
    int          ex_st [8];
    int          ex_len;

    // Expected state path of one instruction, starting and ending in Fetch.
    function automatic void exp_seq(input logic [6:0] op);
        int q[$];
        case (op)
            7'b0000011: q = '{0, 1, 2, 3, 4, 0};
            7'b0100011: q = '{0, 1, 2, 5, 0};
            7'b0110011: q = '{0, 1, 6, 7, 0};
            7'b0010011: q = '{0, 1, 8, 7, 0};
            7'b1101111: q = '{0, 1, 9, 7, 0};
            7'b1100011: q = '{0, 1, 10, 0};
            default:    q = '{0, 1, 0};
        endcase
        ex_len = q.size();
        for (int i = 0; i < 8; i++) ex_st[i] = (i < q.size()) ? q[i] : 0;
    endfunction

    // Control values each state should present, as listed in the state table.
    function automatic logic [16:0] exp_out(input int st, input logic [2:0] f3);
        logic [1:0] rs, aop, sa, sb;
        logic       rw, pcu, as, mw, irw;
        logic [3:0] br;
        rs = 2'b00; aop = 2'b00; sa = 2'b00; sb = 2'b00;
        rw = 0; pcu = 0; as = 0; mw = 0; irw = 0; br = 4'b0000;
        case (st)
            0:  begin irw = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  as = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin as = 1; mw = 1; end
            6:  begin sa = 2'b10; aop = 2'b10; end
            7:  rw = 1;
            8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            9:  begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            10: begin
                sa = 2'b10; aop = 2'b01;
                if (f3 == 3'b000) br = 4'b1000;
                else if (f3 == 3'b001) br = 4'b0100;
                else if (f3 == 3'b101) br = 4'b0010;
                else if (f3 == 3'b100) br = 4'b0001;
            end
            default: ;
        endcase
        return {rs, aop, sa, sb, rw, pcu, as, mw, irw, br};
    endfunction

    // Stimulus only: present one instruction from Fetch and record the trace until Fetch recurs.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3);
        bus.opcode = op;
        bus.funct3 = f3;
        #1;
        tr_len = 0;
        tr_st[0] = int'(dut.state);
        tr_out[0] = obs;
        tr_len = 1;
        while (tr_len < 8) begin
            @(posedge clk);
            @(negedge clk);
            tr_st[tr_len] = int'(dut.state);
            tr_out[tr_len] = obs;
            tr_len++;
            if (tr_st[tr_len-1] == 0) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.opcode = 7'b0000011;
        bus.funct3 = 3'b010;
        repeat (2) @(negedge clk);
        checks++;
        if (dut.state !== 4'd0) begin
            errors++; $display("FAIL reset_state got=%0d exp=0", dut.state);
        end
        checks++;
        if (obs !== FETCH_OUT) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, FETCH_OUT);
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_trace(input string name, input logic [6:0] op, input logic [2:0] f3);
        run_instr(op, f3);
        exp_seq(op);
        checks++;
        if (tr_len !== ex_len) begin
            errors++; $display("FAIL %s_length got=%0d exp=%0d", name, tr_len, ex_len);
        end
        for (int i = 0; i < ex_len && i < tr_len; i++) begin
            checks++;
            if (tr_st[i] !== ex_st[i]) begin
                errors++; $display("FAIL %s_state[%0d] got=%0d exp=%0d", name, i, tr_st[i], ex_st[i]);
            end
            checks++;
            if (tr_out[i] !== exp_out(ex_st[i], f3)) begin
                errors++; $display("FAIL %s_out[%0d] got=%h exp=%h", name, i, tr_out[i], exp_out(ex_st[i], f3));
            end
        end
    endtask

    task automatic test_lw();
        test_trace("lw", 7'b0000011, 3'b010);
        checks++;
        if (tr_out[3][6] !== 1'b1) begin
            errors++; $display("FAIL lw_s3_addrsrc got=%b exp=1", tr_out[3][6]);
        end
        checks++;
        if ({tr_out[4][16:15], tr_out[4][8]} !== 3'b011) begin
            errors++; $display("FAIL lw_s4_wb got=%b exp=011", {tr_out[4][16:15], tr_out[4][8]});
        end
    endtask

    task automatic test_sw();
        test_trace("sw", 7'b0100011, 3'b010);
        for (int i = 0; i < tr_len; i++) begin
            checks++;
            if (tr_out[i][5] !== (tr_st[i] == 5)) begin
                errors++; $display("FAIL sw_memwrite[%0d] got=%b exp=%b", i, tr_out[i][5], tr_st[i] == 5);
            end
        end
    endtask

    task automatic test_rtype_itype();
        test_trace("rtype", 7'b0110011, 3'b000);
        checks++;
        if (tr_out[2][14:13] !== 2'b10) begin
            errors++; $display("FAIL rtype_aluop got=%b exp=10", tr_out[2][14:13]);
        end
        test_trace("itype", 7'b0010011, 3'b001);
        checks++;
        if (tr_out[2][10:9] !== 2'b01) begin
            errors++; $display("FAIL itype_alusrcb got=%b exp=01", tr_out[2][10:9]);
        end
    endtask

    task automatic test_jal();
        test_trace("jal", 7'b1101111, 3'b000);
        checks++;
        if ({tr_out[2][7], tr_out[2][10:9]} !== 3'b110) begin
            errors++; $display("FAIL jal_pc got=%b exp=110", {tr_out[2][7], tr_out[2][10:9]});
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3s [5];
        logic [3:0] want[5];
        f3s  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
        want = '{4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b0000};
        for (int k = 0; k < 5; k++) begin
            test_trace("branch", 7'b1100011, f3s[k]);
            checks++;
            if (tr_out[2][3:0] !== want[k]) begin
                errors++; $display("FAIL branch_strobe f3=%b got=%b exp=%b", f3s[k], tr_out[2][3:0], want[k]);
            end
        end
    endtask

    task automatic test_unknown();
        test_trace("unknown", 7'b1111111, 3'b000);
    endtask

    task automatic test_async_reset();
        int guard;
        bus.opcode = 7'b0000011;
        bus.funct3 = 3'b010;
        guard = 0;
        while (dut.state !== 4'd4 && guard < 10) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        checks++;
        if (dut.state !== 4'd4 || bus.RegWrite !== 1'b1) begin
            errors++; $display("FAIL areset_reach_s4 got=%0d/%b exp=4/1", dut.state, bus.RegWrite);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dut.state !== 4'd0 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL areset_immediate got=%0d/%b exp=0/0", dut.state, bus.RegWrite);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dut.state !== 4'd0 || obs !== FETCH_OUT) begin
            errors++; $display("FAIL areset_held got=%0d/%h exp=0/%h", dut.state, obs, FETCH_OUT);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dut.state !== 4'd1) begin
            errors++; $display("FAIL areset_release got=%0d exp=1", dut.state);
        end
        // Let the lw run out so the next test starts in Fetch.
        guard = 0;
        while (dut.state !== 4'd0 && guard < 10) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[6];
        logic [6:0] op;
        logic [2:0] f3;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) op = 7'($urandom);
            else op = ops[$urandom_range(0, 5)];
            f3 = 3'($urandom);
            test_trace("random", op, f3);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype_itype();
        test_jal();
        test_branch();
        test_unknown();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_main_decoder.md
# multicycle_main_decoder

Control FSM for the multicycle RV32I processor. It sequences each instruction through Fetch, Decode, Execute, Memory and Writeback states. It drives the datapath mux selects, write enables, ALU-op class and per-type branch strobes from the current state, `opcode` and `funct3`. It sits between the instruction register and the datapath, alongside the ALU decoder, which consumes `ALUOp`.

## Interface
- No parameters. The state register is named `state`, is 4 bits wide and is visible hierarchically to benches.
- clk  in  1  clock; all state updates occur on the rising edge.
- reset  in  1  asynchronous, active-low reset; forces `state` to S0 (Fetch).
- opcode  in  7  instruction opcode from the instruction register (instr[6:0]).
- funct3  in  3  instruction funct3 (instr[14:12]).
- ResultSrc  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUOp  out  2  ALU class: 00 add, 01 subtract/compare, 10 decode by funct.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 register A.
- ALUSrcB  out  2  ALU B select: 00 register B (WriteData), 01 ImmExt, 10 constant 4.
- RegWrite  out  1  register file write enable.
- PCUpdate  out  1  unconditional PC write enable.
- AddrSrc  out  1  memory address select: 0 PC, 1 Result.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register and OldPC write enable.
- beq  out  1  branch-if-equal strobe.
- bne  out  1  branch-if-not-equal strobe.
- bge  out  1  branch-if-greater-or-equal (signed) strobe.
- blt  out  1  branch-if-less-than (signed) strobe.

## Operation
State encoding, 4-bit binary:
- S0 Fetch = 0
- S1 Decode = 1
- S2 MemAdr = 2
- S3 MemRead = 3
- S4 MemWB = 4
- S5 MemWrite = 5
- S6 ExecuteR = 6
- S7 ALUWB = 7
- S8 ExecuteI = 8
- S9 JAL = 9
- S10 Branch = 10
- Codes 11–15 are unused.

Transitions:
- S0 → S1.
- From S1, selected by `opcode`:
  - 0000011 (lw) → S2
  - 0100011 (sw) → S2
  - 0110011 (R-type) → S6
  - 0010011 (I-type ALU) → S8
  - 1101111 (jal) → S9
  - 1100011 (branch) → S10
  - any other opcode → S0
- From S2: lw → S3; otherwise (sw) → S5.
- S3 → S4 → S0.
- S5 → S0.
- S6 → S7 → S0.
- S8 → S7.
- S9 → S7.
- S10 → S0.
- Unused codes → S0.

Outputs are Moore (decoded from `state` only), except the branch strobes. Any signal not listed for a state is 0.
- S0: AddrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- S1: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- S2: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- S3: ResultSrc=00, AddrSrc=1.
- S4: ResultSrc=01, RegWrite=1.
- S5: ResultSrc=00, AddrSrc=1, MemWrite=1.
- S6: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- S7: ResultSrc=00, RegWrite=1.
- S8: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- S9: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- S10: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.

Branch strobes:
- Asserted only in S10, decoded combinationally from `funct3`: 000 → beq, 001 → bne, 100 → blt, 101 → bge.
- Any other `funct3` in S10 asserts no strobe.
- At most one strobe is high at any time.
- The strobes are 0 in every other state.

## Timing
- One state transition per rising edge of `clk`.
- Instruction latencies: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; branch 3 cycles; unrecognised opcode 2 cycles.
- `opcode` must be stable during S1 and S2. `funct3` must be stable during S10.
- Outputs settle combinationally after a state change or input change. There are no output registers.
- Reset:
  - `reset`=0 forces `state`=S0 immediately, regardless of `clk`.
  - While reset is held, outputs show the S0 values: IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10, all other outputs 0.
  - Asserting reset mid-instruction aborts the instruction with no further writes.
  - After `reset` rises, the first rising edge moves the FSM to S1.

## Test plan
- lw (opcode 0000011, funct3 010) from reset: state sequence 0,1,2,3,4,0. S3 has AddrSrc=1. S4 has ResultSrc=01 and RegWrite=1.
- sw (0100011): sequence 0,1,2,5,0. MemWrite=1 only in S5.
- R-type (0110011): sequence 0,1,6,7,0. ALUOp=10 in S6. Then I-type (0010011, funct3 001): sequence 0,1,8,7,0 with ALUSrcB=01 in S8.
- jal (1101111): sequence 0,1,9,7,0. PCUpdate=1 and ALUSrcB=10 in S9.
- Branch (1100011) with funct3 = 000, 001, 100, 101 in turn: sequence 0,1,10,0. In S10 exactly beq, bne, blt or bge respectively is 1. funct3=010 gives all strobes 0.
- Async reset and unknown opcode:
  - Drive `reset` low in S4 of an lw, between clock edges: `state` becomes 0 at once and RegWrite drops to 0.
  - Opcode 1111111: sequence 0,1,0.
